// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB codes, instruction field positions and sequencer states
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_WRAP16 = 3'b110;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    localparam int INSTR_W   = 23;
    localparam int WRITE_BIT = 22;
    localparam int BURST_HI  = 21;
    localparam int BURST_LO  = 19;
    localparam int SEL_BIT   = 18;
    localparam int ADDR_HI   = 17;
    localparam int ADDR_LO   = 8;
    localparam int DATA_HI   = 7;
    localparam int DATA_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// rtl/ahb_burst_addr_gen.sv - next-beat address and last-beat flag for an AHB burst
// Ports: burst (HBURST code), addr (current 10-bit beat address), beat (0-based
// beat index) -> next_addr (address of the following beat), last_beat.
module ahb_burst_addr_gen
    import ahb_pkg::*;
(
    input  logic [2:0] burst,
    input  logic [9:0] addr,
    input  logic [3:0] beat,
    output logic [9:0] next_addr,
    output logic       last_beat
);

    logic [3:0] mask;   // beats - 1; doubles as the wrap boundary mask
    logic       wrap;
    logic [9:0] inc;
    logic [9:0] wmask;

    always_comb begin
        mask = 4'd0;
        unique case (burst)
            BURST_SINGLE, BURST_INCR:  mask = 4'd0;
            BURST_WRAP4, BURST_INCR4:  mask = 4'd3;
            BURST_WRAP8, BURST_INCR8:  mask = 4'd7;
            BURST_WRAP16, BURST_INCR16: mask = 4'd15;
            default:                   mask = 4'd0;
        endcase
    end

    // Even codes above SINGLE are the wrapping bursts.
    assign wrap      = !burst[0] && (mask != 4'd0);
    assign inc       = addr + 10'd1;
    assign wmask     = {6'd0, mask};
    assign next_addr = wrap ? ((addr & ~wmask) | (inc & wmask)) : inc;
    assign last_beat = (beat == mask);

endmodule

// File: rtl/ahb_instr_sequencer.sv
// rtl/ahb_instr_sequencer.sv - fetches 23-bit instructions and executes them as AHB-Lite transfers
// Ports: HCLK/HRESETn clock and async reset; start pulse; pc/instruction memory
// interface; AHB master outputs HADDR/HTRANS/HWRITE/HBURST/HSIZE/HWDATA with
// HRDATA/HREADY/HRESP from the slave; rd_valid/rd_data/rd_addr read sideband;
// busy/done/err status.
module ahb_instr_sequencer
    import ahb_pkg::*;
#(
    parameter int LAST_PC = 45,
    parameter int HADDR_W = 32,
    parameter int DATA_W  = 8
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               start,
    output logic [9:0]         pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic [HADDR_W-1:0] HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HBURST,
    output logic [2:0]         HSIZE,
    output logic [DATA_W-1:0]  HWDATA,
    input  logic [DATA_W-1:0]  HRDATA,
    input  logic               HREADY,
    input  logic               HRESP,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic [10:0]        rd_addr,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t     state, state_nxt;
    logic       write_q, sel_q;
    logic [2:0] burst_q;
    logic [9:0] addr_q;     // address of the beat currently in its data phase
    logic [7:0] data_q;
    logic [3:0] beat_q;
    logic [9:0] next_addr;
    logic       last_beat;
    logic       at_last_pc;
    logic [9:0] haddr_low;

    ahb_burst_addr_gen u_addr_gen (
        .burst     (burst_q),
        .addr      (addr_q),
        .beat      (beat_q),
        .next_addr (next_addr),
        .last_beat (last_beat)
    );

    assign at_last_pc = (pc == 10'(LAST_PC));
    assign HWRITE     = write_q;
    assign HBURST     = burst_q;
    assign HSIZE      = 3'b000;
    assign HWDATA     = DATA_W'(data_q);
    assign HADDR      = HADDR_W'({sel_q, haddr_low});

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_FETCH;
            ST_FETCH:         state_nxt = ST_ADDR;
            ST_ADDR:          state_nxt = ST_DATA;
            ST_DATA: begin
                // An ERROR completion abandons the rest of the burst.
                if (HREADY && (HRESP || last_beat))
                    state_nxt = at_last_pc ? ST_DONE : ST_FETCH;
            end
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        HTRANS    = HTRANS_IDLE;
        busy      = 1'b0;
        done      = 1'b0;
        haddr_low = addr_q;
        unique case (state)
            ST_FETCH: busy = 1'b1;
            ST_ADDR: begin
                busy   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
            end
            ST_DATA: begin
                busy = 1'b1;
                // Next beat's address phase overlaps this data phase; an
                // ERROR response withdraws it immediately.
                if (!HRESP && !last_beat) begin
                    HTRANS    = HTRANS_SEQ;
                    haddr_low = next_addr;
                end
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pc       <= 10'd0;
            write_q  <= 1'b0;
            sel_q    <= 1'b0;
            burst_q  <= 3'd0;
            addr_q   <= 10'd0;
            data_q   <= 8'd0;
            beat_q   <= 4'd0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= 11'd0;
        end else begin
            rd_valid <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pc  <= 10'd0;
                        err <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    write_q <= instruction[WRITE_BIT];
                    burst_q <= instruction[BURST_HI:BURST_LO];
                    sel_q   <= instruction[SEL_BIT];
                    addr_q  <= instruction[ADDR_HI:ADDR_LO];
                    data_q  <= instruction[DATA_HI:DATA_LO];
                    beat_q  <= 4'd0;
                end
                ST_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err <= 1'b1;
                        end else begin
                            if (!write_q) begin
                                rd_valid <= 1'b1;
                                rd_data  <= HRDATA;
                                rd_addr  <= {sel_q, addr_q};
                            end
                            if (!last_beat) begin
                                addr_q <= next_addr;
                                beat_q <= beat_q + 4'd1;
                            end
                        end
                        if ((HRESP || last_beat) && !at_last_pc)
                            pc <= pc + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ahb_instr_sequencer.md
Name: ahb_instr_sequencer

Overview:
- Downstream consumer of the instruction memory. Drives `pc`, registers each 23-bit instruction and executes it as an AHB-Lite master transfer toward the slave interconnect.
- Instruction format: WRITE[22], BURST[21:19], SEL[18], ADDR[17:8], DATA[7:0].
- Read results are reported on a sideband strobe. The block runs from `start` until a programmable last instruction, then halts.

Parameters:
- LAST_PC, 45, index of the final instruction executed before `done`.
- HADDR_W, 32, AHB address width; HADDR = {zeros, SEL, ADDR}.
- DATA_W, 8, AHB data width (HSIZE fixed to byte, 3'b000).

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution from pc 0 when idle or done.
- pc  out  10  instruction memory address.
- instruction  in  23  instruction at `pc`; combinational from memory.
- HADDR  out  HADDR_W  transfer address.
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  out  1  copy of WRITE.
- HBURST  out  3  copy of BURST.
- HSIZE  out  3  constant 000.
- HWDATA  out  DATA_W  write data.
- HRDATA  in  DATA_W  read data.
- HREADY  in  1  transfer done / wait-state control.
- HRESP  in  1  0=OKAY, 1=ERROR.
- rd_valid  out  1  one-cycle strobe per completed read beat.
- rd_data  out  DATA_W  captured HRDATA.
- rd_addr  out  11  {SEL, ADDR} of the captured beat.
- busy  out  1  high in FETCH/ADDR/DATA.
- done  out  1  high after LAST_PC completes; cleared by `start`.
- err  out  1  sticky; set on any ERROR response; cleared by `start`.

Behaviour:
- Reset values (asynchronous, applied immediately, including mid-burst):
  - All outputs 0; HTRANS=IDLE; pc=0; state=IDLE.
  - No pending transfer survives reset.
- States and transitions:
  - IDLE -> FETCH on `start`.
  - FETCH: `pc` stable; instruction registered at the end of the cycle -> ADDR.
  - ADDR: HTRANS=NONSEQ; HADDR, HWRITE, HBURST driven from the registered instruction -> DATA.
  - DATA: HWDATA=DATA held until HREADY=1.
    - If beats remain, the next beat's address phase overlaps: HTRANS=SEQ, next HADDR.
    - On the last beat, HTRANS=IDLE.
    - When the last beat completes with HREADY=1: if pc==LAST_PC -> DONE, else pc+1 -> FETCH.
  - DONE: HTRANS=IDLE; `done`=1; `start` -> FETCH with pc=0.
- Address-phase outputs hold while HREADY=0.
- Beat count from BURST: 000/001 -> 1 (INCR executes as single), 010/011 -> 4, 100/101 -> 8, 110/111 -> 16.
- Next-beat address:
  - INCR*: ADDR+1 modulo 1024.
  - WRAP*: low log2(beats) bits increment and wrap; upper ADDR bits held.
  - SEL is never modified.
- Write bursts: every beat writes the same DATA byte.
- Reads: each beat's HRDATA is sampled on the HREADY=1 edge. rd_valid, rd_data and rd_addr are registered and appear in the following cycle.
- Latency, zero wait states: FETCH, ADDR, DATA = 3 cycles per single instruction. Each extra burst beat adds 1 cycle; each wait state adds 1 cycle.
- ERROR response:
  - First cycle (HRESP=1, HREADY=0): HTRANS=IDLE.
  - Second cycle (HRESP=1, HREADY=1): remaining beats abandoned; err=1; no rd_valid for that beat; proceeds to next pc or DONE as normal.
- `start` is ignored while busy.

Decomposition:
- Package ahb_pkg: HTRANS and HBURST codes, instruction field bit positions, state enum.
- Sub-module ahb_burst_addr_gen:
  - Inputs: BURST, current ADDR, beat counter.
  - Outputs: next ADDR and last-beat flag (pure combinational helper).
- The sequencer holds the FSM, pc, and output registers.

Test Plan:
- Reset, then `start`; pc0 = write, single, SEL0, ADDR 0x001, DATA 0x01; HREADY=1 -> cycle 2 HTRANS=NONSEQ, HADDR=0x001, HWRITE=1; cycle 3 HWDATA=0x01, HTRANS=IDLE; cycle 4 pc=1.
- Single read of SEL1 ADDR 0x001, slave returns HRDATA=0x5A -> rd_valid pulses for exactly one cycle, rd_data=0x5A, rd_addr=0x401; err=0.
- Same write with HREADY held low 2 cycles in the data phase -> HWDATA and HADDR stable throughout; pc increments 2 cycles later than in the zero-wait case.
- WRAP4 write at 0x006 -> HADDR 0x006, 0x007, 0x004, 0x005 with HTRANS NONSEQ, SEQ, SEQ, SEQ. INCR4 at 0x3FE -> 0x3FE, 0x3FF, 0x000, 0x001.
- Two-cycle ERROR on beat 2 of an INCR4 read -> HTRANS=IDLE in the first error cycle, beats 3-4 not issued, err=1, next instruction fetched.
- LAST_PC=3 -> done=1 after the pc 3 transfer, HTRANS=IDLE. HRESETn low mid-burst -> HTRANS=IDLE and pc=0 immediately; no activity until `start`.
